// File: rtl/nios_div_pkg.sv
// -----------------------------------------------------------------------------
// nios_div_pkg
// Shared types and constants for the sequential restoring divider
// (nios_div_cell).
//   div_state_e       : divider FSM states
//   DIV_ITERS         : restoring steps per operation (= operand width)
//   DIV_ZERO_QUOTIENT : quotient reported for a zero divisor (all ones)
// -----------------------------------------------------------------------------
package nios_div_pkg;

    localparam int DIV_ITERS = 32;

    localparam logic [DIV_ITERS-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage : nios_div_pkg

// File: rtl/nios_div_cell_if.sv
// -----------------------------------------------------------------------------
// nios_div_cell_if
// Request/response bundle between the ALU issue logic (master) and the
// divider (slave).
//   A_div_start     : request pulse, sampled only while the divider is idle
//   A_div_signed    : 1 = two's-complement operation, 0 = unsigned
//   A_div_src1      : dividend
//   A_div_src2      : divisor
//   A_div_busy      : operation in flight
//   A_div_done      : one-cycle result-valid pulse
//   A_div_quotient  : quotient
//   A_div_remainder : remainder
//   A_div_by_zero   : divisor was zero (valid with done)
// -----------------------------------------------------------------------------
interface nios_div_cell_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  A_div_start;
    logic                  A_div_signed;
    logic [DATA_WIDTH-1:0] A_div_src1;
    logic [DATA_WIDTH-1:0] A_div_src2;
    logic                  A_div_busy;
    logic                  A_div_done;
    logic [DATA_WIDTH-1:0] A_div_quotient;
    logic [DATA_WIDTH-1:0] A_div_remainder;
    logic                  A_div_by_zero;

    modport master (
        output A_div_start, A_div_signed, A_div_src1, A_div_src2,
        input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder,
               A_div_by_zero
    );

    modport slave (
        input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
        output A_div_busy, A_div_done, A_div_quotient, A_div_remainder,
               A_div_by_zero
    );

endinterface : nios_div_cell_if

// File: rtl/nios_div_step.sv
// -----------------------------------------------------------------------------
// nios_div_step
// One combinational radix-2 restoring division step.
//   rem_i : partial remainder
//   dvd_i : dividend bits still to be consumed; quotient bits enter at LSB
//   dsr_i : divisor magnitude
//   rem_o : partial remainder after the step
//   dvd_o : shift register after the step (new quotient bit at LSB)
// -----------------------------------------------------------------------------
module nios_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] dvd_i,
    input  logic [DATA_WIDTH-1:0] dsr_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] dvd_o
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                borrow;

    // {rem, dvd} << 1: the remainder gains the dividend's MSB. The extra
    // top bit keeps the shifted value exact before the trial subtract.
    assign shifted = {rem_i, dvd_i[DATA_WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_i};
    // Because rem_i < dsr_i, a negative difference always lands with its
    // top bit set, so that bit is the borrow.
    assign borrow  = diff[DATA_WIDTH];

    assign rem_o = borrow ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    assign dvd_o = {dvd_i[DATA_WIDTH-2:0], ~borrow};

endmodule : nios_div_step

// File: rtl/nios_div_cell.sv
// -----------------------------------------------------------------------------
// nios_div_cell
// Sequential 32-bit integer divider serving DIV/DIVU/REM/REMU. Restoring
// radix-2, one step per cycle, fixed 34-cycle start-to-done latency.
//   clk    : system clock
//   reset  : synchronous active-high reset; aborts any operation in flight
//   div_if : request/response bundle (slave side), see nios_div_cell_if
// Signed operations divide magnitudes and fix the signs afterwards, so the
// quotient truncates toward zero and the remainder takes the dividend's sign.
// -----------------------------------------------------------------------------
module nios_div_cell
    import nios_div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_ITERS,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    nios_div_cell_if.slave  div_if
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    div_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] rem_q;       // partial remainder
    logic [DATA_WIDTH-1:0] dvd_q;       // dividend in, quotient out
    logic [DATA_WIDTH-1:0] dsr_q;       // divisor magnitude
    logic [DATA_WIDTH-1:0] src1_q;      // raw dividend for the zero-divisor result
    logic                  neg_quo_q;
    logic                  neg_rem_q;
    logic                  zero_q;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic                  by_zero_q;

    logic                  accept;
    logic                  neg_a, neg_b;
    logic [DATA_WIDTH-1:0] abs_a, abs_b;
    logic [DATA_WIDTH-1:0] step_rem, step_dvd;

    // A start is taken in IDLE and also in DONE, which gives back-to-back
    // issue without a dead cycle.
    assign accept = div_if.A_div_start && (state_q == IDLE || state_q == DONE);

    // Magnitudes use modulo negation; -2^(W-1) maps to itself, which makes
    // the overflow case fall out without special handling.
    assign neg_a = div_if.A_div_signed & div_if.A_div_src1[DATA_WIDTH-1];
    assign neg_b = div_if.A_div_signed & div_if.A_div_src2[DATA_WIDTH-1];
    assign abs_a = neg_a ? -div_if.A_div_src1 : div_if.A_div_src1;
    assign abs_b = neg_b ? -div_if.A_div_src2 : div_if.A_div_src2;

    nios_div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: each always_comb output is defaulted first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (div_if.A_div_start) state_d = ITER;
            ITER: if (cnt_q == LAST_CNT)  state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = div_if.A_div_start ? ITER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign fix-up and zero-divisor override, registered in FIX.
    always_comb begin
        quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
        if (zero_q) begin
            quotient_d  = DATA_WIDTH'(DIV_ZERO_QUOTIENT);
            remainder_d = src1_q;
        end
    end

    // Datapath. Visible results hold from FIX until the next operation
    // reaches FIX; reset clears everything so an aborted run leaves zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            src1_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            by_zero_q   <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= abs_a;
            dsr_q     <= abs_b;
            src1_q    <= div_if.A_div_src1;
            neg_quo_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            zero_q    <= (div_if.A_div_src2 == '0);
        end else if (state_q == ITER) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            rem_q <= step_rem;
            dvd_q <= step_dvd;
        end else if (state_q == FIX) begin
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            by_zero_q   <= zero_q;
        end
    end

    assign div_if.A_div_busy      = (state_q == ITER) || (state_q == FIX);
    assign div_if.A_div_done      = (state_q == DONE);
    assign div_if.A_div_quotient  = quotient_q;
    assign div_if.A_div_remainder = remainder_q;
    assign div_if.A_div_by_zero   = by_zero_q;

endmodule : nios_div_cell
